// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO controller and its producer/consumer.
// The controller sits on the slave side; the master side drives push/pop requests.
interface fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 2
) ();

    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr,
        output rd,
        output clr_err,
        input  wr_en,
        input  w_addr,
        input  r_addr,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr,
        input  rd,
        input  clr_err,
        output wr_en,
        output w_addr,
        output r_addr,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a first-word fall-through FIFO built around an
// external register file; produces write strobe, addresses, level flags and sticky errors.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input logic        clk,
    input logic        rst_n,
    fifo_ctrl_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = ADDR_WIDTH + 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);
    localparam logic [CntW-1:0] AeCnt    = CntW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty;
    logic push_ok, pop_ok;
    logic push_rej, pop_rej;

    // Level flags are pure decodes of the registered occupancy.
    always_comb begin
        full  = (count_q == DepthCnt);
        empty = (count_q == '0);
    end

    // rst_n gating keeps the write strobe low while reset is held, whatever wr does.
    always_comb begin
        push_ok  = bus.wr & ~full & rst_n;
        pop_ok   = bus.rd & ~empty & rst_n;
        push_rej = bus.wr & full;
        pop_rej  = bus.rd & empty;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~bus.clr_err;
        underflow_d = underflow_q & ~bus.clr_err;

        // Pointers wrap naturally at Depth since it is a power of two.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // An error in the same cycle as clr_err wins over the clear.
        if (push_rej) begin
            overflow_d = 1'b1;
        end
        if (pop_rej) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        bus.wr_en        = push_ok;
        bus.w_addr       = wr_ptr_q;
        bus.r_addr       = rd_ptr_q;
        bus.full         = full;
        bus.empty        = empty;
        bus.almost_full  = (count_q >= AfCnt);
        bus.almost_empty = (count_q <= AeCnt);
        bus.count        = count_q;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end

    count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthCnt);

    // Pointer distance must always agree with occupancy modulo Depth.
    ptr_count_agree: assert property (@(posedge clk) disable iff (!rst_n)
        ADDR_WIDTH'(wr_ptr_q - rd_ptr_q) == count_q[ADDR_WIDTH-1:0]);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic,
// compared against a queue-based FIFO model and a bench-side register file.
module tb_fifo_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned D  = 1 << AW;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned AF = D - 1;
    localparam int unsigned AE = 1;
    localparam int unsigned SW = 4 + CW + 2 * AW + 2;

    logic clk = 1'b0;
    logic rst_n;

    fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF),
        .AE_LEVEL  (AE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    logic [7:0]    mem [D];
    logic [7:0]    model_q [$];
    int unsigned   push_total;
    int unsigned   pop_total;
    logic          m_ovf;
    logic          m_udf;

    logic          obs_wr_en;
    logic [7:0]    obs_rdata;
    logic [AW-1:0] obs_waddr;
    logic [AW-1:0] obs_raddr;
    logic          exp_wr_en;
    logic          exp_pop;
    logic [7:0]    exp_rdata;

    function automatic logic [SW-1:0] model_status();
        int unsigned n;
        n = model_q.size();
        return {n == D, n == 0, n >= AF, n <= AE, CW'(n), AW'(push_total % D),
                AW'(pop_total % D), m_ovf, m_udf};
    endfunction

    function automatic logic [SW-1:0] dut_status();
        return {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.count,
                bus.w_addr, bus.r_addr, bus.overflow, bus.underflow};
    endfunction

    function automatic void model_reset();
        model_q.delete();
        push_total = 0;
        pop_total  = 0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endfunction

    // One clock of stimulus: samples combinational outputs before the edge, acts as the
    // register file, advances the model, and leaves registered outputs settled after the edge.
    task automatic drive_cycle(input logic w, input logic r, input logic c, input logic [7:0] d);
        @(negedge clk);
        bus.wr      = w;
        bus.rd      = r;
        bus.clr_err = c;
        #1;
        obs_wr_en = bus.wr_en;
        obs_waddr = bus.w_addr;
        obs_raddr = bus.r_addr;
        obs_rdata = mem[bus.r_addr];
        exp_wr_en = w && (model_q.size() < D);
        exp_pop   = r && (model_q.size() != 0);
        exp_rdata = exp_pop ? model_q[0] : 8'h00;
        if (bus.wr_en) mem[bus.w_addr] = d;
        if (exp_pop) begin
            void'(model_q.pop_front());
            pop_total++;
        end
        if (exp_wr_en) begin
            model_q.push_back(d);
            push_total++;
        end
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && !exp_wr_en) m_ovf = 1'b1;
        if (r && !exp_pop) m_udf = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.wr      = 1'b1;
        bus.rd      = 1'b1;
        bus.clr_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        model_reset();
        n_tests++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_en: got %b want 0", bus.wr_en);
        end
        n_tests++;
        if (dut_status() !== {1'b0, 1'b1, 1'b0, 1'b1, {CW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}, 2'b00})
        begin
            n_fail++;
            $display("FAIL reset_status: got %b want %b", dut_status(), model_status());
        end
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, pat[i]);
            n_tests++;
            if (obs_wr_en !== 1'b1 || obs_waddr !== AW'(i)) begin
                n_fail++;
                $display("FAIL fill_push%0d: wr_en=%b w_addr=%0d want wr_en=1 w_addr=%0d",
                         i, obs_wr_en, obs_waddr, i);
            end
        end
        n_tests++;
        if (bus.full !== 1'b1 || bus.count !== CW'(4) || bus.w_addr !== '0) begin
            n_fail++;
            $display("FAIL fill_end: full=%b count=%0d w_addr=%0d want 1/4/0",
                     bus.full, bus.count, bus.w_addr);
        end
    endtask

    task automatic test_drain();
        logic [7:0] pat [4];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (obs_rdata !== pat[i]) begin
                n_fail++;
                $display("FAIL drain_pop%0d: r_data=%h want %h", i, obs_rdata, pat[i]);
            end
        end
        n_tests++;
        if (bus.empty !== 1'b1 || bus.count !== '0 || bus.r_addr !== '0) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b count=%0d r_addr=%0d want 1/0/0",
                     bus.empty, bus.count, bus.r_addr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            drive_cycle(1'b1, 1'b0, 1'b0, d);
            n_tests++;
            if (bus.count > CW'(1) || dut_status() !== model_status()) begin
                n_fail++;
                $display("FAIL wrap_push%0d: status=%b want %b", i, dut_status(), model_status());
            end
            drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            n_tests++;
            if (obs_rdata !== d || dut_status() !== model_status()) begin
                n_fail++;
                $display("FAIL wrap_pop%0d: r_data=%h status=%b want %h %b",
                         i, obs_rdata, dut_status(), d, model_status());
            end
        end
    endtask

    task automatic test_collisions();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        drive_cycle(1'b1, 1'b1, 1'b0, 8'hA5);
        n_tests++;
        if (obs_wr_en !== 1'b0 || bus.count !== CW'(3) || bus.overflow !== 1'b1
            || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wr_rd: wr_en=%b count=%0d ovf=%b udf=%b want 0/3/1/0",
                     obs_wr_en, bus.count, bus.overflow, bus.underflow);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h5A);
        n_tests++;
        if (obs_wr_en !== 1'b1 || bus.count !== CW'(1) || bus.underflow !== 1'b1
            || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_wr_rd: wr_en=%b count=%0d ovf=%b udf=%b want 1/1/1/1",
                     obs_wr_en, bus.count, bus.overflow, bus.underflow);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_err: ovf=%b udf=%b want 0/0", bus.overflow, bus.underflow);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_set: ovf=%b udf=%b want 0/1", bus.overflow, bus.underflow);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_thresholds();
        logic [1:0] want [3];
        want = '{2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
            n_tests++;
            if ({bus.almost_full, bus.almost_empty} !== want[i] || bus.count !== CW'(i + 1)) begin
                n_fail++;
                $display("FAIL thresh_cnt%0d: af/ae=%b count=%0d want %b/%0d",
                         i + 1, {bus.almost_full, bus.almost_empty}, bus.count, want[i], i + 1);
            end
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        int unsigned bias;
        logic        w;
        logic        r;
        logic        c;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) bias = $urandom_range(20, 80);
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) >= bias);
            if ($urandom_range(0, 3) == 0) r = ~r;
            c = ($urandom_range(0, 15) == 0);
            drive_cycle(w, r, c, 8'($urandom));
            n_tests++;
            if (obs_wr_en !== exp_wr_en) begin
                n_fail++;
                $display("FAIL rand_wr_en[%0d]: got %b want %b", i, obs_wr_en, exp_wr_en);
            end
            if (exp_pop) begin
                n_tests++;
                if (obs_rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL rand_rdata[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
                end
            end
            n_tests++;
            if (dut_status() !== model_status()) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got %b want %b", i, dut_status(), model_status());
            end
        end
    endtask

    task automatic test_async_reset();
        while (model_q.size() > 3) drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        while (model_q.size() < 3) drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        @(negedge clk);
        bus.wr      = 1'b1;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dut_status() !== model_status() || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_now: status=%b wr_en=%b want %b 0",
                     dut_status(), bus.wr_en, model_status());
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (dut_status() !== model_status() || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_hold: status=%b wr_en=%b want %b 0",
                     dut_status(), bus.wr_en, model_status());
        end
        @(negedge clk);
        bus.wr = 1'b0;
        rst_n  = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h77);
        n_tests++;
        if (obs_wr_en !== 1'b1 || obs_waddr !== '0 || bus.count !== CW'(1)) begin
            n_fail++;
            $display("FAIL post_reset_push: wr_en=%b w_addr=%0d count=%0d want 1/0/1",
                     obs_wr_en, obs_waddr, bus.count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < D; i++) mem[i] = 8'h00;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_collisions();
        test_thresholds();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 2, address bits of the companion register file; depth D = 2**ADDR_WIDTH.
REQ-002 Parameter: AF_LEVEL, default D-1, count at or above which almost_full asserts.
REQ-003 Parameter: AE_LEVEL, default 1, count at or below which almost_empty asserts.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: wr  input  1  push request from producer.
REQ-007 Port: rd  input  1  pop request from consumer.
REQ-008 Port: wr_en  output  1  write strobe to register file.
REQ-009 Port: w_addr  output  ADDR_WIDTH  register-file write address.
REQ-010 Port: r_addr  output  ADDR_WIDTH  register-file read address; the file's r_data is valid combinationally at it (first-word fall-through).
REQ-011 Port: full  output  1  count == D.
REQ-012 Port: empty  output  1  count == 0.
REQ-013 Port: almost_full  output  1  count >= AF_LEVEL.
REQ-014 Port: almost_empty  output  1  count <= AE_LEVEL.
REQ-015 Port: count  output  ADDR_WIDTH+1  current occupancy, 0..D.
REQ-016 Port: overflow  output  1  sticky: a push was rejected.
REQ-017 Port: underflow  output  1  sticky: a pop was rejected.
REQ-018 Port: clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-019 Internal state: wr_ptr, rd_ptr (ADDR_WIDTH bits each) and count (ADDR_WIDTH+1 bits), all registered; w_addr = wr_ptr and r_addr = rd_ptr directly.
REQ-020 Accepted push: push_ok = wr & ~full; wr_en = push_ok, combinational, same cycle as wr.
REQ-021 Accepted pop: pop_ok = rd & ~empty; data at r_addr is consumed in the cycle rd is high.
REQ-022 On push_ok, wr_ptr increments by 1 modulo D (wraps D-1 -> 0).
REQ-023 On pop_ok, rd_ptr increments by 1 modulo D.
REQ-024 Count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
REQ-025 Flags full, empty, almost_full and almost_empty are decoded from the registered count and change on the edge following the causing operation.
REQ-026 Full and both wr and rd: only the pop is accepted; the push is dropped, wr_en stays 0, overflow sets, and count goes D -> D-1.
REQ-027 Empty and both wr and rd: only the push is accepted; the pop is dropped, underflow sets, and count goes 0 -> 1.
REQ-028 wr while full (no rd): no state change except overflow <= 1.
REQ-029 rd while empty (no wr): no state change except underflow <= 1.
REQ-030 clr_err clears both sticky flags; if an error event occurs in the same cycle, set wins.
REQ-031 Neither flag clears except by clr_err or reset.

Reset
REQ-032 While rst_n = 0, asynchronously: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
REQ-033 wr_en is 0 during reset regardless of wr.
REQ-034 Reset asserted mid-operation discards all occupancy; no partial pointer update survives.
REQ-035 Release of rst_n is synchronised outside this block; the first accepted operation occurs at the first rising edge after release.

Verification
REQ-036 Fill, ADDR_WIDTH=2: push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> w_addr 0,1,2,3 with wr_en=1; after the 4th edge full=1, count=4, w_addr=0.
REQ-037 Drain: pop 4 times -> r_data 8'h11, 8'h22, 8'h33, 8'h44 in order; then empty=1, count=0, r_addr=0.
REQ-038 Wrap: 6 push/pop pairs interleaved with D=4 -> pointers wrap 3->0; data order preserved; count never exceeds 1.
REQ-039 Full with wr and rd high -> count 4->3, wr_en=0, overflow=1; empty with wr and rd high -> count 0->1, underflow=1; pulse clr_err -> both 0.
REQ-040 Thresholds, defaults: count 3 -> almost_full=1; count 1 -> almost_empty=1; count 2 -> both 0.
REQ-041 Assert rst_n=0 asynchronously at count=3 mid-cycle -> all outputs immediately reach their REQ-032 values; a subsequent push writes w_addr=0.
